// File: rtl/hsync_ctrl.sv
`default_nettype none
//======================================================================
// Module   : hsync_ctrl
// Purpose  : Turns horizontal count-match strobes into registered sync,
//            visible and active levels, a column address and a line-end
//            pulse. Define HSYNC_CTRL_ERR_EN to build the strobe-sequence
//            checker that drives the sticky err flag.
// Revision : 1.0 - initial release
//======================================================================
module hsync_ctrl #(
   parameter int SYNC_ACTIVE_LOW = 1,
   parameter int COL_W           = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hCountEnd,
   input  logic             hBeginPulse,
   input  logic             hEndPulse,
   input  logic             hVisEnd,
   input  logic             hBeginActive,
   input  logic             hEndActive,
   output logic             hSync,
   output logic             hVis,
   output logic             hActive,
   output logic [COL_W-1:0] col,
   output logic             lineEnd,
   output logic             err
);

   localparam logic [1:0] c_ST_VIS   = 2'd0;
   localparam logic [1:0] c_ST_FRONT = 2'd1;
   localparam logic [1:0] c_ST_SYNC  = 2'd2;
   localparam logic [1:0] c_ST_BACK  = 2'd3;
   localparam logic       c_SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

   logic [1:0]       r_state;
   logic [1:0]       w_nextState;
   logic             r_hSync;
   logic             r_hVis;
   logic             r_hActive;
   logic             r_lineEnd;
   logic [COL_W-1:0] r_col;
   logic             w_beginOk;
   logic             w_hActiveNext;
   logic [COL_W-1:0] w_colNext;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= c_ST_VIS;
         r_hVis    <= 1'b1;
         r_hSync   <= ~c_SYNC_ON;
         r_hActive <= 1'b0;
         r_col     <= '0;
         r_lineEnd <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_hVis    <= (w_nextState == c_ST_VIS);
         r_hSync   <= (w_nextState == c_ST_SYNC) ? c_SYNC_ON : ~c_SYNC_ON;
         r_hActive <= w_hActiveNext;
         r_col     <= w_colNext;
         r_lineEnd <= hCountEnd;
      end
   end

   // hCountEnd always wins and resynchronises to the start of a line
   always_comb begin
      w_nextState = r_state;
      if (hCountEnd) begin
         w_nextState = c_ST_VIS;
      end else begin
         case (r_state)
            c_ST_VIS:   if (hVisEnd)     w_nextState = c_ST_FRONT;
            c_ST_FRONT: if (hBeginPulse) w_nextState = c_ST_SYNC;
            c_ST_SYNC:  if (hEndPulse)   w_nextState = c_ST_BACK;
            default:                     w_nextState = r_state;
         endcase
      end
   end

   always_comb begin
      w_beginOk     = !hCountEnd && hBeginActive && (r_state == c_ST_VIS);
      w_hActiveNext = r_hActive;
      if (w_beginOk) begin
         w_hActiveNext = 1'b1;
      end
      if (hCountEnd || hEndActive || (w_nextState != c_ST_VIS)) begin
         w_hActiveNext = 1'b0;
      end
      w_colNext = r_col;
      if (w_beginOk) begin
         w_colNext = '0;
      end else if (r_hActive && w_hActiveNext) begin
         w_colNext = r_col + 1'b1;
      end
   end

`ifdef HSYNC_CTRL_ERR_EN
   logic r_err;
   logic w_seqErr;

   always_comb begin
      w_seqErr = 1'b0;
      if (hCountEnd) begin
         w_seqErr = (r_state != c_ST_BACK);
      end else begin
         case (r_state)
            c_ST_VIS:   w_seqErr = hBeginPulse | hEndPulse;
            c_ST_FRONT: w_seqErr = hVisEnd | hEndPulse;
            c_ST_SYNC:  w_seqErr = hVisEnd | hBeginPulse;
            default:    w_seqErr = hVisEnd | hBeginPulse | hEndPulse;
         endcase
         // A begin paired with an end is a legal zero-length window
         if (hBeginActive && !hEndActive && (r_state != c_ST_VIS)) begin
            w_seqErr = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_seqErr) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   assign hSync   = r_hSync;
   assign hVis    = r_hVis;
   assign hActive = r_hActive;
   assign col     = r_col;
   assign lineEnd = r_lineEnd;

endmodule
`default_nettype wire

// File: tb/tb_hsync_ctrl.sv
`default_nettype none
//======================================================================
// Module   : tb_hsync_ctrl
// Purpose  : Directed line-by-line bench for hsync_ctrl driven from a model
//            800-count horizontal counter with a scoreboard of expected levels.
// Revision : 1.0 - initial release
//======================================================================
module tb_hsync_ctrl;

   localparam int   COL_W          = 10;
   localparam int   H_BEGIN_ACTIVE = 15;
   localparam int   H_BEGIN_PULSE  = 655;
   localparam int   H_END_PULSE    = 751;
   localparam int   H_COUNT_END    = 799;
   localparam logic SYNC_OFF       = 1'b1;

   logic             clk = 1'b0;
   logic             rst;
   logic             hCountEnd;
   logic             hBeginPulse;
   logic             hEndPulse;
   logic             hVisEnd;
   logic             hBeginActive;
   logic             hEndActive;
   logic             hSync;
   logic             hVis;
   logic             hActive;
   logic [COL_W-1:0] col;
   logic             lineEnd;
   logic             err;

   typedef struct packed {
      logic             vis;
      logic             sync;
      logic             act;
      logic             le;
      logic             err;
      logic [COL_W-1:0] col;
   } exp_t;

   exp_t q[$];
   int   testCnt = 0;
   int   failCnt = 0;
   int   cfgVE;
   int   cfgEA;
   int   cfgRstAt;
   bit   cfgDrop;
   int   colStart;
   logic expErr;

   always #5 clk = ~clk;

   hsync_ctrl #(
      .SYNC_ACTIVE_LOW (1),
      .COL_W           (COL_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .hCountEnd    (hCountEnd),
      .hBeginPulse  (hBeginPulse),
      .hEndPulse    (hEndPulse),
      .hVisEnd      (hVisEnd),
      .hBeginActive (hBeginActive),
      .hEndActive   (hEndActive),
      .hSync        (hSync),
      .hVis         (hVis),
      .hActive      (hActive),
      .col          (col),
      .lineEnd      (lineEnd),
      .err          (err)
   );

   task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] want);
      testCnt++;
      assert (obs === want) else begin
         failCnt++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
      end
   endtask

   task automatic popCheck(input int c);
      exp_t e;
      testCnt++;
      assert (q.size() != 0) else begin
         failCnt++;
         $error("FAIL scoreboard@%0d: observed empty queue expected one entry", c);
      end
      if (q.size() != 0) begin
         e = q.pop_front();
         check1($sformatf("hVis@%0d", c),    32'(hVis),    32'(e.vis));
         check1($sformatf("hSync@%0d", c),   32'(hSync),   32'(e.sync));
         check1($sformatf("hActive@%0d", c), 32'(hActive), 32'(e.act));
         check1($sformatf("lineEnd@%0d", c), 32'(lineEnd), 32'(e.le));
         check1($sformatf("err@%0d", c),     32'(err),     32'(e.err));
         check1($sformatf("col@%0d", c),     32'(col),     32'(e.col));
      end
   endtask

   // Expected levels seen during count n, given strobes through count n-1
   function automatic exp_t expectAt(input int n);
      exp_t e;
      bit   afterRst;
      afterRst = (cfgRstAt >= 0) && (n > cfgRstAt);
      e.le  = (n == H_COUNT_END + 1);
      e.err = expErr;
      if (n == H_COUNT_END + 1) begin
         e.vis  = 1'b1;
         e.sync = SYNC_OFF;
         e.act  = 1'b0;
         e.col  = afterRst ? '0 : COL_W'(cfgEA - H_BEGIN_ACTIVE - 1);
      end else begin
         e.vis  = (n <= cfgVE);
         e.sync = (n > H_BEGIN_PULSE && (n <= H_END_PULSE || cfgDrop)) ? ~SYNC_OFF : SYNC_OFF;
         e.act  = !afterRst && (n > H_BEGIN_ACTIVE) && (n <= cfgEA);
         if (afterRst)                 e.col = '0;
         else if (n <= H_BEGIN_ACTIVE) e.col = COL_W'(colStart);
         else if (n <= cfgEA)          e.col = COL_W'(n - H_BEGIN_ACTIVE - 1);
         else                          e.col = COL_W'(cfgEA - H_BEGIN_ACTIVE - 1);
      end
      return e;
   endfunction

   task automatic runLine(input int ve, input int ea, input bit inj, input bit drop, input int rstAt);
      cfgVE    = ve;
      cfgEA    = ea;
      cfgDrop  = drop;
      cfgRstAt = rstAt;
      for (int c = 0; c <= H_COUNT_END; c++) begin
         popCheck(c);
         rst          = (c == rstAt);
         hCountEnd    = (c == H_COUNT_END);
         hVisEnd      = (c == ve);
         hBeginPulse  = (c == H_BEGIN_PULSE) || (inj && c == 100);
         hEndPulse    = (c == H_END_PULSE) && !drop;
         hBeginActive = (c == H_BEGIN_ACTIVE);
         hEndActive   = (c == ea);
         if (c == rstAt) expErr = 1'b0;
`ifdef HSYNC_CTRL_ERR_EN
         if ((inj && c == 100) || (drop && c == H_COUNT_END)) expErr = 1'b1;
`endif
         q.push_back(expectAt(c + 1));
         @(negedge clk);
      end
      colStart = (rstAt >= 0) ? 0 : ea - H_BEGIN_ACTIVE - 1;
   endtask

   initial begin
      exp_t resetExp;
      rst          = 1'b1;
      hCountEnd    = 1'b0;
      hBeginPulse  = 1'b0;
      hEndPulse    = 1'b0;
      hVisEnd      = 1'b0;
      hBeginActive = 1'b0;
      hEndActive   = 1'b0;
      expErr       = 1'b0;
      colStart     = 0;
      cfgRstAt     = -1;
      resetExp     = '{vis: 1'b1, sync: SYNC_OFF, act: 1'b0, le: 1'b0, err: 1'b0, col: '0};
      @(negedge clk);
      q.push_back(resetExp);
      @(negedge clk);

      runLine(639, 623, 1'b0, 1'b0, -1);  // plain line from reset
      runLine(639, 623, 1'b0, 1'b0, -1);  // col holds 607 into the new line
      runLine(639, 623, 1'b1, 1'b0, -1);  // stray hBeginPulse at count 100
      runLine(639, 623, 1'b0, 1'b0, -1);  // normal line, err stays sticky
      runLine(639, 623, 1'b0, 1'b1, -1);  // hEndPulse dropped
      runLine(639, 623, 1'b0, 1'b0, -1);  // recovery line
      runLine(639, 639, 1'b0, 1'b0, -1);  // hEndActive coincides with hVisEnd
      runLine(639, 623, 1'b0, 1'b0, 400); // reset mid-line
      runLine(639, 623, 1'b0, 1'b0, -1);  // resync from BACK without err
      popCheck(0);

      $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
      $finish;
   end

endmodule
`default_nettype wire
